// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage pipeline. It tracks the EX and MEM destination registers,
// drives the EX-aligned forwarding selects, and inserts one bubble on each load-use hazard.
module hazard_forward_ctrl #(
   parameter int REG_BITS = 5,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic [REG_BITS-1:0] id_rd,
   input  logic                id_RegDst,
   input  logic                id_RegWr,
   input  logic                id_MemToReg,
   input  logic                id_uses_rt,
   input  logic                flush,
   output logic                stall,
   output logic                ex_forward_a,
   output logic                ex_forward_b,
   output logic                mem_forward_a,
   output logic                mem_forward_b,
   output logic [CNT_W-1:0]    stall_count
);

   logic [REG_BITS-1:0] id_dst;
   logic                id_w;
   logic                ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic                bubble;

   logic [REG_BITS-1:0] ex_dst_q, ex_dst_d;
   logic                ex_w_q, ex_w_d;
   logic                ex_ld_q, ex_ld_d;
   logic [REG_BITS-1:0] mem_dst_q;
   logic                mem_w_q;
   logic                fwd_ex_a_q, fwd_ex_a_d;
   logic                fwd_ex_b_q, fwd_ex_b_d;
   logic                fwd_mem_a_q, fwd_mem_a_d;
   logic                fwd_mem_b_q, fwd_mem_b_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   assign id_dst = id_RegDst ? id_rd : id_rt;
   // Writes to $0 are never tracked, so a tracked destination is never $0.
   assign id_w   = id_valid & id_RegWr & (id_dst != '0);

   // The younger producer in EX takes priority over the older one in MEM.
   assign ex_hit_a  = ex_w_q & (ex_dst_q == id_rs);
   assign ex_hit_b  = id_uses_rt & ex_w_q & (ex_dst_q == id_rt);
   assign mem_hit_a = mem_w_q & (mem_dst_q == id_rs) & ~ex_hit_a;
   assign mem_hit_b = id_uses_rt & mem_w_q & (mem_dst_q == id_rt) & ~ex_hit_b;

   assign stall  = ~rst & id_valid & ~flush & ex_w_q & ex_ld_q & (ex_hit_a | ex_hit_b);
   assign bubble = flush | stall;

   // NOTE: every signal driven here gets a default first, so no latch can be inferred.
   always_comb begin
      ex_dst_d    = id_dst;
      ex_w_d      = id_w;
      ex_ld_d     = id_w & id_MemToReg;
      fwd_ex_a_d  = id_valid & ex_hit_a;
      fwd_ex_b_d  = id_valid & ex_hit_b;
      fwd_mem_a_d = id_valid & mem_hit_a;
      fwd_mem_b_d = id_valid & mem_hit_b;
      cnt_d       = cnt_q;
      if (bubble) begin
         ex_dst_d    = ex_dst_q;
         ex_w_d      = 1'b0;
         ex_ld_d     = 1'b0;
         fwd_ex_a_d  = 1'b0;
         fwd_ex_b_d  = 1'b0;
         fwd_mem_a_d = 1'b0;
         fwd_mem_b_d = 1'b0;
      end
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_dst_q    <= '0;
         ex_w_q      <= 1'b0;
         ex_ld_q     <= 1'b0;
         mem_dst_q   <= '0;
         mem_w_q     <= 1'b0;
         fwd_ex_a_q  <= 1'b0;
         fwd_ex_b_q  <= 1'b0;
         fwd_mem_a_q <= 1'b0;
         fwd_mem_b_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         ex_dst_q    <= ex_dst_d;
         ex_w_q      <= ex_w_d;
         ex_ld_q     <= ex_ld_d;
         mem_dst_q   <= ex_dst_q;
         mem_w_q     <= ex_w_q;
         fwd_ex_a_q  <= fwd_ex_a_d;
         fwd_ex_b_q  <= fwd_ex_b_d;
         fwd_mem_a_q <= fwd_mem_a_d;
         fwd_mem_b_q <= fwd_mem_b_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ex_forward_a  = fwd_ex_a_q;
   assign ex_forward_b  = fwd_ex_b_q;
   assign mem_forward_a = fwd_mem_a_q;
   assign mem_forward_b = fwd_mem_b_q;
   assign stall_count   = cnt_q;

endmodule
